lfsr_rand_gen: RTL and testbench

Registered pseudo-random number source for game setup: a Galois LFSR of parametrised width that advances a parametrised number of steps per clock. It delivers OUT_W-bit values through a valid/ready handshake and uses rejection sampling to keep them in the range [0, bound). It sits between the setup controller and mine placement, supplying row/column candidates. It also supports seed loading, all-zero lock-up protection and a saturating reject counter.

---
 rtl/lfsr_pkg.sv | 109 ++++++++++
 rtl/lfsr_advance.sv | 33 +++
 rtl/lfsr_rand_gen.sv | 131 +++++++++++++
 tb/tb_lfsr_rand_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared constants and helpers for the Galois LFSR random source.
//   - LFSR_TAPS   : maximal-length tap masks (XAPP052 table), indexed by the
//                   LFSR length 3..64. Entries 1 and 2 are unused and zero.
//                   Tap n maps to mask bit n-1.
//   - lfsr_step() : one right-shifting Galois step of a width-bit LFSR.
//   - Legal parameter ranges used by the elaboration checks.
// ---------------------------------------------------------------------------
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W       = 64;
  localparam int unsigned LFSR_WIDTH_MIN   = 3;
  localparam int unsigned LFSR_WIDTH_MAX   = 64;
  localparam int unsigned LFSR_STEPS_MIN   = 1;
  localparam int unsigned LFSR_OUT_W_MIN   = 1;
  localparam int unsigned LFSR_REJECT_CNT_W = 8;

  // Builds a feedback mask from up to four tap positions (0 = unused).
  function automatic logic [LFSR_MAX_W-1:0] tap_mask(input int unsigned t0,
                                                      input int unsigned t1,
                                                      input int unsigned t2,
                                                      input int unsigned t3);
    logic [LFSR_MAX_W-1:0] m;
    m = '0;
    if (t0 != 0) m[6'(t0 - 1)] = 1'b1;
    if (t1 != 0) m[6'(t1 - 1)] = 1'b1;
    if (t2 != 0) m[6'(t2 - 1)] = 1'b1;
    if (t3 != 0) m[6'(t3 - 1)] = 1'b1;
    return m;
  endfunction

  localparam logic [LFSR_MAX_W-1:0] LFSR_TAPS [1:64] = '{
    64'h0,                                   // 1  (unused)
    64'h0,                                   // 2  (unused)
    tap_mask( 3,  2,  0,  0),
    tap_mask( 4,  3,  0,  0),
    tap_mask( 5,  3,  0,  0),
    tap_mask( 6,  5,  0,  0),
    tap_mask( 7,  6,  0,  0),
    tap_mask( 8,  6,  5,  4),
    tap_mask( 9,  5,  0,  0),
    tap_mask(10,  7,  0,  0),
    tap_mask(11,  9,  0,  0),
    tap_mask(12,  6,  4,  1),
    tap_mask(13,  4,  3,  1),
    tap_mask(14,  5,  3,  1),
    tap_mask(15, 14,  0,  0),
    tap_mask(16, 15, 13,  4),
    tap_mask(17, 14,  0,  0),
    tap_mask(18, 11,  0,  0),
    tap_mask(19,  6,  2,  1),
    tap_mask(20, 17,  0,  0),
    tap_mask(21, 19,  0,  0),
    tap_mask(22, 21,  0,  0),
    tap_mask(23, 18,  0,  0),
    tap_mask(24, 23, 22, 17),
    tap_mask(25, 22,  0,  0),
    tap_mask(26,  6,  2,  1),
    tap_mask(27,  5,  2,  1),
    tap_mask(28, 25,  0,  0),
    tap_mask(29, 27,  0,  0),
    tap_mask(30,  6,  4,  1),
    tap_mask(31, 28,  0,  0),
    tap_mask(32, 22,  2,  1),
    tap_mask(33, 20,  0,  0),
    tap_mask(34, 27,  2,  1),
    tap_mask(35, 33,  0,  0),
    tap_mask(36, 25,  0,  0),
    tap_mask(37,  5,  4,  3) | tap_mask(2, 1, 0, 0),
    tap_mask(38,  6,  5,  1),
    tap_mask(39, 35,  0,  0),
    tap_mask(40, 38, 21, 19),
    tap_mask(41, 38,  0,  0),
    tap_mask(42, 41, 20, 19),
    tap_mask(43, 42, 38, 37),
    tap_mask(44, 43, 18, 17),
    tap_mask(45, 44, 42, 41),
    tap_mask(46, 45, 26, 25),
    tap_mask(47, 42,  0,  0),
    tap_mask(48, 47, 21, 20),
    tap_mask(49, 40,  0,  0),
    tap_mask(50, 49, 24, 23),
    tap_mask(51, 50, 36, 35),
    tap_mask(52, 49,  0,  0),
    tap_mask(53, 52, 38, 37),
    tap_mask(54, 53, 18, 17),
    tap_mask(55, 31,  0,  0),
    tap_mask(56, 55, 35, 34),
    tap_mask(57, 50,  0,  0),
    tap_mask(58, 39,  0,  0),
    tap_mask(59, 58, 38, 37),
    tap_mask(60, 59,  0,  0),
    tap_mask(61, 60, 46, 45),
    tap_mask(62, 61,  6,  5),
    tap_mask(63, 62,  0,  0),
    tap_mask(64, 63, 61, 60)
  };

  // One Galois step: shift right, fold the tap mask in when the bit leaving
  // the register is 1. Bits above 'width' in 'state' must be zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] state,
                                                       input int unsigned           width);
    logic [LFSR_MAX_W-1:0] shifted;
    shifted = state >> 1;
    return state[0] ? (shifted ^ LFSR_TAPS[7'(width)]) : shifted;
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// ---------------------------------------------------------------------------
// lfsr_advance
// Combinational look-ahead: applies STEPS Galois steps to 'state'.
// Parameters: WIDTH (LFSR length), STEPS (steps per clock).
// Ports:
//   state  in  WIDTH  current LFSR state
//   nxt    out WIDTH  state after STEPS single steps
// ---------------------------------------------------------------------------
module lfsr_advance
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEPS = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] nxt
);

  // Each stage owns its own nets so the chain is a plain feed-forward path.
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_out;
    if (g == 0) begin : g_first
      assign s_in = state;
    end else begin : g_next
      assign s_in = g_step[g-1].s_out;
    end
    assign s_out = WIDTH'(lfsr_step(LFSR_MAX_W'(s_in), WIDTH));
  end

  assign nxt = g_step[STEPS-1].s_out;

endmodule

// File: rtl/lfsr_rand_gen.sv
// ---------------------------------------------------------------------------
// lfsr_rand_gen
// Registered pseudo-random source: Galois LFSR advancing STEPS per clock,
// values delivered over valid/ready, optional rejection sampling to [0,bound).
// Parameters: WIDTH (3..64), STEPS (1..WIDTH), OUT_W (1..WIDTH),
//             SEED (reset/fallback state, nonzero in WIDTH bits).
// Ports:
//   clk         in   1      system clock
//   rst_n       in   1      asynchronous active-low reset
//   seed_load   in   1      load 'seed' into the LFSR (highest priority)
//   seed        in   WIDTH  seed value; all-zero falls back to SEED
//   bound       in   OUT_W  exclusive upper limit, 0 = full range
//   out_ready   in   1      consumer accepts out_data
//   out_valid   out  1      out_data valid
//   out_data    out  OUT_W  random value
//   reject_cnt  out  8      saturating count of rejected candidates
// Build option: define LFSR_RANGE_REJECT_EN to enable rejection sampling;
// without it 'bound' is ignored, every candidate is accepted and reject_cnt
// stays 0.
// ---------------------------------------------------------------------------
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned           WIDTH = 16,
  parameter int unsigned           STEPS = 1,
  parameter int unsigned           OUT_W = 8,
  parameter logic [LFSR_MAX_W-1:0] SEED  = 64'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         seed_load,
  input  logic [WIDTH-1:0]             seed,
  input  logic [OUT_W-1:0]             bound,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [OUT_W-1:0]             out_data,
  output logic [LFSR_REJECT_CNT_W-1:0] reject_cnt
);

  // Elaboration-time parameter checks
  if (WIDTH < LFSR_WIDTH_MIN || WIDTH > LFSR_WIDTH_MAX) begin : g_bad_width
    $error("lfsr_rand_gen: WIDTH must be in 3..64");
  end
  if (STEPS < LFSR_STEPS_MIN || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_rand_gen: STEPS must be in 1..WIDTH");
  end
  if (OUT_W < LFSR_OUT_W_MIN || OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_rand_gen: OUT_W must be in 1..WIDTH");
  end
  if (SEED[WIDTH-1:0] == '0) begin : g_bad_seed
    $error("lfsr_rand_gen: SEED must be nonzero in WIDTH bits");
  end

  localparam logic [WIDTH-1:0]             SEED_W  = SEED[WIDTH-1:0];
  localparam logic [LFSR_REJECT_CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]             state_q, state_d;
  logic                         out_valid_q, out_valid_d;
  logic [OUT_W-1:0]             out_data_q, out_data_d;
  logic [LFSR_REJECT_CNT_W-1:0] reject_cnt_q, reject_cnt_d;

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] seed_safe;
  logic [OUT_W-1:0] cand;
  logic             adv;
  logic             accept;

  lfsr_advance #(
    .WIDTH (WIDTH),
    .STEPS (STEPS)
  ) u_advance (
    .state (state_q),
    .nxt   (nxt)
  );

  // All-zero is the lock-up state of the LFSR; never load it.
  assign seed_safe = (seed == '0) ? SEED_W : seed;
  assign cand      = nxt[OUT_W-1:0];
  assign adv       = !seed_load && (!out_valid_q || out_ready);

`ifdef LFSR_RANGE_REJECT_EN
  assign accept = (bound == '0) || (cand < bound);
`else
  logic unused_bound;
  assign unused_bound = ^bound;
  assign accept       = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    reject_cnt_d = reject_cnt_q;
    if (seed_load) begin
      // out_data is left as is; a coincident handshake has already completed.
      state_d      = seed_safe;
      out_valid_d  = 1'b0;
      reject_cnt_d = '0;
    end else if (adv) begin
      state_d = nxt;
      if (accept) begin
        out_data_d  = cand;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        if (reject_cnt_q != CNT_MAX) begin
          reject_cnt_d = reject_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEED_W;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      reject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_rand_gen
// Self-checking bench for lfsr_rand_gen (default WIDTH=16, OUT_W=8) plus a
// STEPS=2 instance. Follows LFSR_RANGE_REJECT_EN the same way the RTL does.
// ---------------------------------------------------------------------------
module tb_lfsr_rand_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed;
  logic [7:0]  bound;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [7:0]  reject_cnt;

  logic        seed_load2 = 1'b0;
  logic [15:0] seed2      = 16'h0;
  logic [7:0]  bound2     = 8'h0;
  logic        out_ready2 = 1'b1;
  logic        out_valid2;
  logic [7:0]  out_data2;
  logic [7:0]  reject_cnt2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_rand_gen #(
    .WIDTH (16),
    .STEPS (1),
    .OUT_W (8),
    .SEED  (64'hACE1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .bound      (bound),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .reject_cnt (reject_cnt)
  );

  lfsr_rand_gen #(
    .WIDTH (16),
    .STEPS (2),
    .OUT_W (8),
    .SEED  (64'hACE1)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load2),
    .seed       (seed2),
    .bound      (bound2),
    .out_ready  (out_ready2),
    .out_valid  (out_valid2),
    .out_data   (out_data2),
    .reject_cnt (reject_cnt2)
  );

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic        ld;
    logic [15:0] seed;
    logic [7:0]  bound;
    logic        rdy;
    logic        valid;
    logic [7:0]  data;
    logic [7:0]  cnt;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] m_state;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [7:0]  m_cnt;

  function automatic logic [15:0] step16(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hD008) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_state = 16'hACE1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_cnt   = 8'h00;
    sb.delete();
  endtask

  task automatic model_step(input logic ld, input logic [15:0] sd,
                            input logic [7:0] bd, input logic rd);
    logic [7:0] c;
    logic       ok;
    if (ld) begin
      m_state = (sd == 16'h0) ? 16'hACE1 : sd;
      m_valid = 1'b0;
      m_cnt   = 8'h00;
    end else if (!m_valid || rd) begin
      m_state = step16(m_state);
      c = m_state[7:0];
`ifdef LFSR_RANGE_REJECT_EN
      ok = (bd == 8'h00) || (c < bd);
`else
      ok = 1'b1;
`endif
      if (ok) begin
        m_data  = c;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic drive(input logic ld, input logic [15:0] sd, input logic [7:0] bd,
                       input logic rd, output exp_t got);
    exp_t e;
    seed_load = ld;
    seed      = sd;
    bound     = bd;
    out_ready = rd;
    model_step(ld, sd, bd, rd);
    sb.push_back('{valid: m_valid, data: m_data, cnt: m_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_valid", 64'(out_valid), 64'(e.valid));
    check("sb_data", 64'(out_data), 64'(e.data));
    check("sb_cnt", 64'(reject_cnt), 64'(e.cnt));
    got = '{valid: out_valid, data: out_data, cnt: reject_cnt};
  endtask

  function automatic vec_t mk(input logic ld, input logic [15:0] sd, input logic [7:0] bd,
                              input logic rd, input logic v, input logic [7:0] d,
                              input logic [7:0] c);
    vec_t t;
    t.ld = ld; t.seed = sd; t.bound = bd; t.rdy = rd;
    t.valid = v; t.data = d; t.cnt = c;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    exp_t g;

    // Table entries assume the DUT holds out_data=0x3C, state 0x433C on entry.
    tbl.push_back(mk(1, 16'h0000, 8'h00, 1, 0, 8'h3C, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 1, 8'h78, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 1, 8'h3C, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 1, 8'h9E, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 1, 8'hCF, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 1, 8'h6F, 8'd0));
    tbl.push_back(mk(1, 16'h0000, 8'd100, 1, 0, 8'h6F, 8'd0));
`ifdef LFSR_RANGE_REJECT_EN
    tbl.push_back(mk(0, 16'h0000, 8'd100, 1, 0, 8'h6F, 8'd1));
    tbl.push_back(mk(0, 16'h0000, 8'd100, 1, 1, 8'h3C, 8'd1));
`else
    tbl.push_back(mk(0, 16'h0000, 8'd100, 1, 1, 8'h78, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'd100, 1, 1, 8'h3C, 8'd0));
`endif
    tbl.push_back(mk(1, 16'h8678, 8'h00, 1, 0, 8'h3C, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 1, 8'h3C, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h30, 0, 1, 8'h3C, 8'd0));
`ifdef LFSR_RANGE_REJECT_EN
    tbl.push_back(mk(0, 16'h0000, 8'h30, 1, 0, 8'h3C, 8'd1));
    tbl.push_back(mk(0, 16'h0000, 8'h30, 0, 0, 8'h3C, 8'd2));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 1, 8'h6F, 8'd2));
`else
    tbl.push_back(mk(0, 16'h0000, 8'h30, 1, 1, 8'h9E, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h30, 0, 1, 8'h9E, 8'd0));
    tbl.push_back(mk(0, 16'h0000, 8'h00, 1, 1, 8'hCF, 8'd0));
`endif

    // Reset state
    rst_n = 1'b0; seed_load = 1'b0; seed = 16'h0; bound = 8'h0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'h0);
    check("rst_cnt", 64'(reject_cnt), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'hACE1);
    check("rst_valid_s2", 64'(out_valid2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge evaluates even with out_ready low; then stall 5 cycles.
    drive(0, 16'h0, 8'h0, 0, g);
    check("first_valid", 64'(g.valid), 64'd1);
    check("first_data", 64'(g.data), 64'h78);
    check("first_state", 64'(dut.state_q), 64'h8678);
    check("s2_first_valid", 64'(out_valid2), 64'd1);
    check("s2_first_data", 64'(out_data2), 64'h3C);
    check("s2_first_cnt", 64'(reject_cnt2), 64'd0);
    for (int unsigned i = 0; i < 5; i++) begin
      drive(0, 16'h0, 8'h0, 0, g);
      if (i == 0) check("s2_second_data", 64'(out_data2), 64'hCF);
      check("stall_data", 64'(g.data), 64'h78);
      check("stall_state", 64'(dut.state_q), 64'h8678);
    end
    drive(0, 16'h0, 8'h0, 1, g);
    check("after_stall_data", 64'(g.data), 64'h3C);

    // Table-driven vectors
    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].seed, tbl[i].bound, tbl[i].rdy, g);
      check($sformatf("vec%0d_valid", i), 64'(g.valid), 64'(tbl[i].valid));
      check($sformatf("vec%0d_data", i), 64'(g.data), 64'(tbl[i].data));
      check($sformatf("vec%0d_cnt", i), 64'(g.cnt), 64'(tbl[i].cnt));
    end

    // Asynchronous reset mid-stream while out_valid=1
    check("pre_areset_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", 64'(out_valid), 64'd0);
    check("areset_data", 64'(out_data), 64'h0);
    check("areset_cnt", 64'(reject_cnt), 64'd0);
    check("areset_state", 64'(dut.state_q), 64'hACE1);
    model_reset();
    seed_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 16'h0, 8'h0, 1, g);
    check("restart_data", 64'(g.data), 64'h78);

    // Reject-counter saturation with bound=1
    for (int unsigned i = 0; i < 300; i++) begin
      drive(0, 16'h0, 8'd1, 1, g);
    end
`ifdef LFSR_RANGE_REJECT_EN
    check("sat_cnt", 64'(reject_cnt), 64'd255);
`else
    check("sat_cnt", 64'(reject_cnt), 64'd0);
`endif

    // seed_load with zero seed clears the counter and falls back to SEED
    drive(1, 16'h0000, 8'd1, 1, g);
    check("reload_cnt", 64'(g.cnt), 64'd0);
    check("reload_valid", 64'(g.valid), 64'd0);
    check("reload_state", 64'(dut.state_q), 64'hACE1);
    drive(0, 16'h0, 8'h0, 1, g);
    check("reload_data", 64'(g.data), 64'h78);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
